// File: rtl/uart_receiver.sv
// UART receiver: oversampled start-bit validation, LSB-first data capture and stop-bit check.
// Good bytes appear on dout with a one-cycle dout_valid; bad stop bits give a one-cycle frame_err.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low on a tick
// START   | counting to mid-start-bit to reject glitches
// DATA    | sampling DATA_BITS data bits at mid-bit
// STOP    | sampling the stop bit at mid-bit
// BREAK   | stop bit was low; wait for the line to return high
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 system_clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BP_W  = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BP_W-1:0]  BP_LAST  = BP_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BP_W-1:0]      bitpos_q, bitpos_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 frame_err_q, frame_err_d;

    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitpos_d     = bitpos_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (clken) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d  = S_DATA;
                            cnt_d    = '0;
                            bitpos_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shreg_d  = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        cnt_d    = '0;
                        bitpos_d = bitpos_q + 1'b1;
                        if (bitpos_q == BP_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            dout_d       = shreg_q;
                            dout_valid_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Held-low line stays here so a break reports one error, not repeated frames.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bitpos_q     <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bitpos_q     <= bitpos_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames plus hand-written
// back-to-back, glitch, break and mid-frame reset sequences.
module tb_uart_receiver;

    localparam int BIT_CYC = 64;  // 16 ticks per bit, one tick every 4 clocks

    logic       system_clk = 1'b0;
    logic       reset      = 1'b0;
    logic       clken      = 1'b0;
    logic       rx         = 1'b1;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .clken      (clken),
        .rx         (rx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 system_clk = ~system_clk;

    initial begin : clken_gen
        logic [1:0] phase;
        phase = 2'd0;
        forever begin
            @(negedge system_clk);
            clken = (phase == 2'd3);
            phase = phase + 2'd1;
        end
    end

    int         tick_cnt    = 0;
    int         valid_cnt   = 0;
    int         err_cnt     = 0;
    int         busy_cycles = 0;
    int         valid_tick  = 0;
    int         fall_tick   = 0;
    logic [7:0] dq[$];

    always @(posedge system_clk) if (clken) tick_cnt++;

    always @(negedge system_clk) begin
        if (dout_valid) begin
            valid_cnt++;
            valid_tick = tick_cnt;
            dq.push_back(dout);
        end
        if (frame_err) err_cnt++;
        if (rx_busy) busy_cycles++;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge system_clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge system_clk);
        rx = b;
        wait_cyc(BIT_CYC - 1);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        @(negedge system_clk);
        rx = 1'b0;
        fall_tick = tick_cnt;
        wait_cyc(BIT_CYC - 1);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop_bit);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int v0, e0;
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[3] = '{8'h01, 1'b1, 1, 0, 8'h01};
        vecs[4] = '{8'h80, 1'b1, 1, 0, 8'h80};

        // Reset and idle
        reset = 1'b0;
        rx    = 1'b1;
        wait_cyc(10);
        check("reset_dout", int'(dout), 0);
        check("reset_busy", int'(rx_busy), 0);
        reset = 1'b1;
        wait_cyc(1000);
        check("idle_dout", int'(dout), 0);
        check("idle_busy", int'(rx_busy), 0);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_err_cnt", err_cnt, 0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            @(negedge system_clk);
            rx = 1'b1;
            wait_cyc(4 * BIT_CYC);
            check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].exp_dout));
            if (vecs[i].exp_valid == 1) begin
                // detection is tick 1 or 2 after the edge; stop sampled 152 ticks later
                check($sformatf("vec%0d_latency", i),
                      int'((valid_tick - fall_tick) inside {[153:154]}), 1);
            end
        end

        // Back-to-back 0x00 then 0xFF
        dq.delete();
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        @(negedge system_clk);
        rx = 1'b1;
        wait_cyc(4 * BIT_CYC);
        check("b2b_valid", valid_cnt - v0, 2);
        check("b2b_err", err_cnt - e0, 0);
        check("b2b_first", (dq.size() > 0) ? int'(dq[0]) : -1, 8'h00);
        check("b2b_second", (dq.size() > 1) ? int'(dq[1]) : -1, 8'hFF);

        // Glitch: 3 ticks low
        v0 = valid_cnt;
        e0 = err_cnt;
        busy_cycles = 0;
        @(negedge system_clk);
        rx = 1'b0;
        wait_cyc(12);
        rx = 1'b1;
        wait_cyc(4 * BIT_CYC);
        check("glitch_strobes", (valid_cnt - v0) + (err_cnt - e0), 0);
        check("glitch_busy_cycles", busy_cycles, 32);
        check("glitch_busy_end", int'(rx_busy), 0);

        // Break: 40 bit times low, then a good 0x81 frame
        v0 = valid_cnt;
        e0 = err_cnt;
        @(negedge system_clk);
        rx = 1'b0;
        wait_cyc(40 * BIT_CYC);
        rx = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check("break_err", err_cnt - e0, 1);
        check("break_valid_none", valid_cnt - v0, 0);
        send_frame(8'h81, 1'b1);
        @(negedge system_clk);
        rx = 1'b1;
        wait_cyc(4 * BIT_CYC);
        check("break_valid", valid_cnt - v0, 1);
        check("break_err_total", err_cnt - e0, 1);
        check("break_dout", int'(dout), 8'h81);

        // Reset during bit 4 of 0x5A
        v0 = valid_cnt;
        e0 = err_cnt;
        @(negedge system_clk);
        rx = 1'b0;
        wait_cyc(BIT_CYC - 1);
        for (int i = 0; i < 4; i++) send_bit(logic'((8'h5A >> i) & 8'h01));
        @(negedge system_clk);
        rx = 1'b1;  // bit 4 of 0x5A
        wait_cyc(32);
        check("midframe_busy", int'(rx_busy), 1);
        reset = 1'b0;
        #1;
        check("rst_busy_drop", int'(rx_busy), 0);
        check("rst_dout", int'(dout), 0);
        wait_cyc(10);
        reset = 1'b1;
        wait_cyc(6 * BIT_CYC);
        check("abort_strobes", (valid_cnt - v0) + (err_cnt - e0), 0);
        send_frame(8'h12, 1'b1);
        @(negedge system_clk);
        rx = 1'b1;
        wait_cyc(4 * BIT_CYC);
        check("post_rst_valid", valid_cnt - v0, 1);
        check("post_rst_err", err_cnt - e0, 0);
        check("post_rst_dout", int'(dout), 8'h12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
